abus_input_conditioner: RTL

- Front-end stage directly upstream of the A-bus/SDRAM bridge's A-bus port.
- Takes raw asynchronous Saturn A-bus pins and synchronises them into the 116 MHz system clock domain.
- Glitch-filters the control lines and tracks chip-select framing.
- Emits clean single-cycle read/write request strobes, with captured address, data and byte enables, for the bridge to consume.

---
 rtl/abus_cond_pkg.sv | 37 +++
 rtl/abus_glitch_filter.sv | 52 +++++
 rtl/abus_input_conditioner.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/abus_cond_pkg.sv
// Shared types and constants for the A-bus input conditioner.
// Optional statistics counters are enabled with the ABUS_COND_STATS_EN macro.
package abus_cond_pkg;

  localparam int unsigned ABUS_HI_W   = 10;
  localparam int unsigned ABUS_DATA_W = 16;
  localparam int unsigned ABUS_ADDR_W = ABUS_HI_W + ABUS_DATA_W;
  localparam int unsigned REGION_W    = 2;
  localparam int unsigned CS_W        = 3;
  localparam int unsigned WR_W        = 2;
  localparam int unsigned CTRL_W      = CS_W + 1 + WR_W;
  localparam int unsigned FILT_CNT_W  = 3;
  localparam int unsigned STAT_W      = 16;
  localparam int unsigned STAT_SUM_W  = STAT_W + 1;
  localparam int unsigned STAT_INC_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } cond_state_t;

  // Synchronised address/data pins, kept together so they share one delay line.
  typedef struct packed {
    logic [ABUS_HI_W-1:0]   hi;
    logic [ABUS_DATA_W-1:0] ad;
  } abus_bus_t;

  function automatic logic [STAT_W-1:0] stat_sat_add(input logic [STAT_W-1:0] acc,
                                                     input logic [STAT_INC_W-1:0] inc);
    logic [STAT_SUM_W-1:0] sum;
    sum = {1'b0, acc} + STAT_SUM_W'(inc);
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/abus_glitch_filter.sv
// One control pin: multi-flop synchroniser followed by a consecutive-sample filter.
// Reports a one-cycle glitch pulse whenever a partial run of mismatches is discarded.
module abus_glitch_filter
  import abus_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic filt,
  output logic glitch
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_CNT_W-1:0]  cnt;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Flip only after FILTER_LEN consecutive differing samples; a short run is a glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt   <= 1'b1;
      cnt    <= '0;
      glitch <= 1'b0;
    end else begin
      glitch <= 1'b0;
      if (sample != filt) begin
        if (cnt == FILT_CNT_W'(FILTER_LEN - 1)) begin
          filt <= sample;
          cnt  <= '0;
        end else begin
          cnt <= cnt + FILT_CNT_W'(1);
        end
      end else if (cnt != '0) begin
        cnt    <= '0;
        glitch <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/abus_input_conditioner.sv
// Synchronises and filters raw Saturn A-bus pins and emits single-cycle access strobes.
// Define ABUS_COND_STATS_EN to add saturating read/write/glitch counters.
module abus_input_conditioner
  import abus_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2,
  parameter int unsigned ADDR_INC    = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ABUS_HI_W-1:0]   abus_address,
  input  logic [ABUS_DATA_W-1:0] abus_addressdata_in,
  input  logic [CS_W-1:0]        abus_chipselect,
  input  logic                   abus_read,
  input  logic [WR_W-1:0]        abus_writebyteenable_n,
  output logic [ABUS_ADDR_W-1:0] trans_address,
  output logic [REGION_W-1:0]    trans_region,
  output logic [ABUS_DATA_W-1:0] trans_writedata,
  output logic [WR_W-1:0]        trans_byteenable,
  output logic                   read_req,
  output logic                   read_end,
  output logic                   write_req,
  output logic                   abort,
  output logic                   protocol_error,
  output logic                   busy
`ifdef ABUS_COND_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_reads,
  output logic [STAT_W-1:0]      stat_writes,
  output logic [STAT_W-1:0]      stat_glitches
`endif
);

  logic [CTRL_W-1:0]   ctrl_raw;
  logic [CTRL_W-1:0]   ctrl_f;
  logic [CTRL_W-1:0]   glitch;
  logic [CS_W-1:0]     cs_f;
  logic                rd_f;
  logic [WR_W-1:0]     wr_f;
  logic [CS_W-1:0]     cs_low;
  logic                cs_any;
  logic                cs_multi;
  logic                wr_any;
  logic [REGION_W-1:0] region_c;
  logic [WR_W-1:0]     be_acc;
  abus_bus_t           bus_q [SYNC_STAGES];
  abus_bus_t           bus_s;
  cond_state_t         state;

  assign ctrl_raw = {abus_writebyteenable_n, abus_read, abus_chipselect};

  for (genvar i = 0; i < int'(CTRL_W); i++) begin : g_filt
    abus_glitch_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_filt (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (ctrl_raw[i]),
      .filt    (ctrl_f[i]),
      .glitch  (glitch[i])
    );
  end

  assign cs_f = ctrl_f[CS_W-1:0];
  assign rd_f = ctrl_f[CS_W];
  assign wr_f = ctrl_f[CTRL_W-1:CS_W+1];

  // Address/data delay line matches the control synchroniser depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) bus_q[i] <= '0;
    end else begin
      bus_q[0] <= {abus_address, abus_addressdata_in};
      for (int i = 1; i < int'(SYNC_STAGES); i++) bus_q[i] <= bus_q[i-1];
    end
  end

  assign bus_s    = bus_q[SYNC_STAGES-1];
  assign cs_low   = ~cs_f;
  assign cs_any   = |cs_low;
  assign cs_multi = (cs_low & (cs_low - CS_W'(1))) != '0;
  assign wr_any   = ~(&wr_f);

  // Lowest active chip select wins.
  always_comb begin
    region_c = REGION_W'(2);
    if (cs_low[1]) region_c = REGION_W'(1);
    if (cs_low[0]) region_c = REGION_W'(0);
  end

  // Access sequencer; chip-select release is always checked first so abort wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      trans_address    <= '0;
      trans_region     <= '0;
      trans_writedata  <= '0;
      trans_byteenable <= '0;
      be_acc           <= '0;
      read_req         <= 1'b0;
      read_end         <= 1'b0;
      write_req        <= 1'b0;
      abort            <= 1'b0;
      protocol_error   <= 1'b0;
      busy             <= 1'b0;
    end else begin
      read_req       <= 1'b0;
      read_end       <= 1'b0;
      write_req      <= 1'b0;
      abort          <= 1'b0;
      protocol_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_any) begin
            trans_address  <= bus_s;
            trans_region   <= region_c;
            protocol_error <= cs_multi;
            busy           <= 1'b1;
            state          <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!cs_any) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (!rd_f && !wr_any) begin
            read_req <= 1'b1;
            state    <= ST_READ;
          end else if (!rd_f && wr_any) begin
            protocol_error <= 1'b1;
          end else if (wr_any) begin
            // Entry cycle already has a strobe low, so it seeds the accumulator.
            be_acc          <= ~wr_f;
            trans_writedata <= bus_s.ad;
            state           <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (!cs_any) begin
            abort <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rd_f) begin
            read_end      <= 1'b1;
            trans_address <= trans_address + ABUS_ADDR_W'(ADDR_INC);
            state         <= ST_ARMED;
          end
        end
        ST_WRITE: begin
          if (!cs_any) begin
            abort <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (!wr_any) begin
            trans_byteenable <= be_acc;
            write_req        <= 1'b1;
            trans_address    <= trans_address + ABUS_ADDR_W'(ADDR_INC);
            state            <= ST_ARMED;
          end else begin
            trans_writedata <= bus_s.ad;
            be_acc          <= be_acc | ~wr_f;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ABUS_COND_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads    <= '0;
      stat_writes   <= '0;
      stat_glitches <= '0;
    end else begin
      stat_reads    <= stat_sat_add(stat_reads, STAT_INC_W'(read_end));
      stat_writes   <= stat_sat_add(stat_writes, STAT_INC_W'(write_req));
      stat_glitches <= stat_sat_add(stat_glitches, STAT_INC_W'($countones(glitch)));
    end
  end
`else
  logic unused_glitch;
  assign unused_glitch = ^glitch;
`endif

endmodule
